// File: rtl/vga_layer_mixer.sv
// Priority compositor between the VGA sync generator and the DAC pins.
// Config is shadowed at frame start; output and sync leave together after two cycles.
module vga_layer_mixer #(
    parameter int NUM_LAYERS   = 4,
    parameter int COLOR_BITS   = 4,
    parameter int FLASH_FRAMES = 30,
    parameter bit VS_ACT_LOW   = 1'b1
) (
    input  logic                               vga_clk,
    input  logic                               reset,
    input  logic                               disparea_in,
    input  logic                               hs_in,
    input  logic                               vs_in,
    input  logic [NUM_LAYERS-1:0]              layer_hit,
    input  logic [NUM_LAYERS*3*COLOR_BITS-1:0] layer_color,
    input  logic [NUM_LAYERS-1:0]              cfg_enable,
    input  logic [NUM_LAYERS-1:0]              cfg_flash,
    input  logic [3*COLOR_BITS-1:0]            cfg_bg,
    output logic                               hs_out,
    output logic                               vs_out,
    output logic [COLOR_BITS-1:0]              vga_r,
    output logic [COLOR_BITS-1:0]              vga_g,
    output logic [COLOR_BITS-1:0]              vga_b,
    output logic                               frame_tick
);

    localparam int PW = 3 * COLOR_BITS;
    localparam int CW = $clog2(FLASH_FRAMES + 1);
    localparam logic SYNC_IDLE = VS_ACT_LOW;
    localparam logic VS_ACTIVE = ~VS_ACT_LOW;
    localparam logic [CW-1:0] CNT_LAST = CW'(FLASH_FRAMES - 1);

    logic                  vsPrev_q;
    logic [NUM_LAYERS-1:0] enSh_q;
    logic [NUM_LAYERS-1:0] flSh_q;
    logic [PW-1:0]         bgSh_q;
    logic [CW-1:0]         frameCnt_q;
    logic [CW-1:0]         frameCnt_d;
    logic                  flashPhase_q;
    logic                  frameTick_q;

    logic                  disp1_q;
    logic                  hs1_q;
    logic                  vs1_q;
    logic                  valid1_q;
    logic [PW-1:0]         color1_q;
    logic [PW-1:0]         bg1_q;

    logic                  hsOut_q;
    logic                  vsOut_q;
    logic [PW-1:0]         pixel_q;
    logic [PW-1:0]         pixel_d;

    logic                  frameStart;
    logic                  frameWrap;
    logic [NUM_LAYERS-1:0] visible;
    logic                  winValid;
    logic [PW-1:0]         winColor;

    assign frameStart = (vs_in == VS_ACTIVE) && (vsPrev_q != VS_ACTIVE);
    assign frameWrap  = (frameCnt_q == CNT_LAST);
    assign frameCnt_d = frameWrap ? '0 : frameCnt_q + CW'(1);

    // Flashing layers are suppressed during the odd flash phase only.
    assign visible = layer_hit & enSh_q & (~flSh_q | {NUM_LAYERS{~flashPhase_q}});

    always_comb begin
        winValid = 1'b0;
        winColor = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (visible[i]) begin
                winValid = 1'b1;
                winColor = layer_color[i*PW +: PW];
            end
        end
    end

    assign pixel_d = disp1_q ? (valid1_q ? color1_q : bg1_q) : '0;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            vsPrev_q     <= SYNC_IDLE;
            enSh_q       <= '0;
            flSh_q       <= '0;
            bgSh_q       <= '0;
            frameCnt_q   <= '0;
            flashPhase_q <= 1'b0;
            frameTick_q  <= 1'b0;
            disp1_q      <= 1'b0;
            hs1_q        <= SYNC_IDLE;
            vs1_q        <= SYNC_IDLE;
            valid1_q     <= 1'b0;
            color1_q     <= '0;
            bg1_q        <= '0;
            hsOut_q      <= SYNC_IDLE;
            vsOut_q      <= SYNC_IDLE;
            pixel_q      <= '0;
        end else begin
            vsPrev_q    <= vs_in;
            frameTick_q <= frameStart;
            // Shadows load here, so the S1 decision this cycle still uses the old frame's config.
            if (frameStart) begin
                enSh_q     <= cfg_enable;
                flSh_q     <= cfg_flash;
                bgSh_q     <= cfg_bg;
                frameCnt_q <= frameCnt_d;
                if (frameWrap) begin
                    flashPhase_q <= ~flashPhase_q;
                end
            end
            disp1_q  <= disparea_in;
            hs1_q    <= hs_in;
            vs1_q    <= vs_in;
            valid1_q <= winValid;
            color1_q <= winColor;
            bg1_q    <= bgSh_q;
            hsOut_q  <= hs1_q;
            vsOut_q  <= vs1_q;
            pixel_q  <= pixel_d;
        end
    end

    assign hs_out     = hsOut_q;
    assign vs_out     = vsOut_q;
    assign frame_tick = frameTick_q;
    assign {vga_r, vga_g, vga_b} = pixel_q;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Bench for vga_layer_mixer: two instances (flash period 30 and 2) share stimulus and are
// compared each cycle against a frame-count based reference model plus fixed vectors.
module tb_vga_layer_mixer;

    logic        vgaClk = 1'b0;
    logic        reset;
    logic        dispareaIn;
    logic        hsIn;
    logic        vsIn;
    logic [3:0]  layerHit;
    logic [47:0] layerColor;
    logic [3:0]  cfgEnable;
    logic [3:0]  cfgFlash;
    logic [11:0] cfgBg;

    logic       hsOutA, vsOutA, tickA;
    logic [3:0] rA, gA, bA;
    logic       hsOutB, vsOutB, tickB;
    logic [3:0] rB, gB, bB;

    int checks = 0;
    int errors = 0;
    int tickCountB = 0;

    // Reference model state
    logic [3:0]  mEn, mFl;
    logic [11:0] mBg;
    int          mK;
    logic        mVsPrev;
    logic [11:0] s1PixA, s1PixB, outPixA, outPixB;
    logic        s1Hs, s1Vs, outHs, outVs, outTick;

    always #5 vgaClk = ~vgaClk;

    vga_layer_mixer dutA (
        .vga_clk(vgaClk), .reset(reset), .disparea_in(dispareaIn), .hs_in(hsIn), .vs_in(vsIn),
        .layer_hit(layerHit), .layer_color(layerColor), .cfg_enable(cfgEnable),
        .cfg_flash(cfgFlash), .cfg_bg(cfgBg), .hs_out(hsOutA), .vs_out(vsOutA),
        .vga_r(rA), .vga_g(gA), .vga_b(bA), .frame_tick(tickA)
    );

    vga_layer_mixer #(.FLASH_FRAMES(2)) dutB (
        .vga_clk(vgaClk), .reset(reset), .disparea_in(dispareaIn), .hs_in(hsIn), .vs_in(vsIn),
        .layer_hit(layerHit), .layer_color(layerColor), .cfg_enable(cfgEnable),
        .cfg_flash(cfgFlash), .cfg_bg(cfgBg), .hs_out(hsOutB), .vs_out(vsOutB),
        .vga_r(rB), .vga_g(gB), .vga_b(bB), .frame_tick(tickB)
    );

    typedef struct {
        logic [3:0]  hit;
        logic        disp;
        logic [11:0] expRgb;
    } vec_t;

    vec_t        vecs[8];
    logic [11:0] flashExp[6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [11:0] composite(input logic disp, input logic [3:0] hit,
                                              input logic [3:0] en, input logic [3:0] fl,
                                              input logic [11:0] bg, input logic [47:0] colors,
                                              input bit phase);
        if (!disp) return 12'h000;
        for (int i = 0; i < 4; i++) begin
            if (hit[i] && en[i] && !(fl[i] && phase)) return colors[i*12 +: 12];
        end
        return bg;
    endfunction

    // One clock cycle: advance the model with the inputs present at the edge, then compare.
    task automatic applyStimulus();
        logic fs;
        if (reset) begin
            mEn = 4'h0; mFl = 4'h0; mBg = 12'h000; mK = 0; mVsPrev = 1'b1;
            s1PixA = 12'h000; s1PixB = 12'h000; s1Hs = 1'b1; s1Vs = 1'b1;
            outPixA = 12'h000; outPixB = 12'h000; outHs = 1'b1; outVs = 1'b1; outTick = 1'b0;
        end else begin
            fs = (vsIn == 1'b0) && (mVsPrev != 1'b0);
            outPixA = s1PixA;
            outPixB = s1PixB;
            outHs = s1Hs;
            outVs = s1Vs;
            s1PixA = composite(dispareaIn, layerHit, mEn, mFl, mBg, layerColor, ((mK / 30) % 2) == 1);
            s1PixB = composite(dispareaIn, layerHit, mEn, mFl, mBg, layerColor, ((mK / 2) % 2) == 1);
            s1Hs = hsIn;
            s1Vs = vsIn;
            outTick = fs;
            if (fs) begin
                mEn = cfgEnable; mFl = cfgFlash; mBg = cfgBg; mK++;
            end
            mVsPrev = vsIn;
        end
        @(posedge vgaClk);
        #1;
        if (tickB === 1'b1) tickCountB++;
        checkOutput("modelRgbA", {rA, gA, bA}, outPixA);
        checkOutput("modelRgbB", {rB, gB, bB}, outPixB);
        checkOutput("modelHsA", hsOutA, outHs);
        checkOutput("modelVsA", vsOutA, outVs);
        checkOutput("modelHsB", hsOutB, outHs);
        checkOutput("modelVsB", vsOutB, outVs);
        checkOutput("modelTickA", tickA, outTick);
        checkOutput("modelTickB", tickB, outTick);
    endtask

    task automatic hold(input int n);
        repeat (n) applyStimulus();
    endtask

    task automatic pulseVs();
        vsIn = 1'b0;
        applyStimulus();
        vsIn = 1'b1;
        applyStimulus();
    endtask

    initial begin
        vecs[0] = '{4'b0110, 1'b1, 12'hF00};
        vecs[1] = '{4'b0000, 1'b1, 12'h00F};
        vecs[2] = '{4'b0001, 1'b0, 12'h000};
        vecs[3] = '{4'b1000, 1'b1, 12'h123};
        vecs[4] = '{4'b1111, 1'b1, 12'h888};
        vecs[5] = '{4'b1100, 1'b1, 12'h0F0};
        vecs[6] = '{4'b0100, 1'b0, 12'h000};
        vecs[7] = '{4'b1010, 1'b1, 12'hF00};
        flashExp = '{12'h888, 12'h00F, 12'h00F, 12'h888, 12'h888, 12'h00F};

        reset = 1'b1; hsIn = 1'b0; vsIn = 1'b0; dispareaIn = 1'b0; layerHit = 4'h0;
        layerColor = {12'h123, 12'h0F0, 12'hF00, 12'h888};
        cfgEnable = 4'h0; cfgFlash = 4'h0; cfgBg = 12'h000;

        // T1: reset with low syncs
        repeat (3) begin
            applyStimulus();
            checkOutput("t1Rgb", {rA, gA, bA}, 12'h000);
            checkOutput("t1Hs", hsOutA, 1'b1);
            checkOutput("t1Vs", vsOutA, 1'b1);
            checkOutput("t1Tick", tickA, 1'b0);
        end
        hsIn = 1'b1; vsIn = 1'b1; reset = 1'b0; dispareaIn = 1'b1; layerHit = 4'b0001;
        hold(4);
        checkOutput("blackBeforeFrame", {rA, gA, bA}, 12'h000);

        // T2: load config at a frame start, then the fixed vectors
        cfgEnable = 4'hF; cfgBg = 12'h00F;
        vsIn = 1'b0;
        applyStimulus();
        checkOutput("t2TickHigh", tickA, 1'b1);
        vsIn = 1'b1;
        applyStimulus();
        checkOutput("t2TickLow", tickA, 1'b0);
        for (int v = 0; v < 8; v++) begin
            layerHit = vecs[v].hit;
            dispareaIn = vecs[v].disp;
            hold(2);
            checkOutput($sformatf("vecA%0d", v), {rA, gA, bA}, vecs[v].expRgb);
            checkOutput($sformatf("vecB%0d", v), {rB, gB, bB}, vecs[v].expRgb);
        end

        // T3: blanking and hsync alignment
        dispareaIn = 1'b0; layerHit = 4'b0001;
        hold(2);
        checkOutput("t3Blank", {rA, gA, bA}, 12'h000);
        hsIn = 1'b0;
        applyStimulus();
        checkOutput("t3HsEarly", hsOutA, 1'b1);
        hsIn = 1'b1;
        applyStimulus();
        checkOutput("t3HsDelayed", hsOutA, 1'b0);
        applyStimulus();
        checkOutput("t3HsBack", hsOutA, 1'b1);

        // T4: mid-frame config change is held off until the next frame start
        dispareaIn = 1'b1; layerHit = 4'b0010; cfgEnable = 4'h0;
        hold(2);
        checkOutput("t4StillL1", {rA, gA, bA}, 12'hF00);
        pulseVs();
        hold(2);
        checkOutput("t4NowBg", {rA, gA, bA}, 12'h00F);

        // T5: flash sequencing on the two-frame instance
        reset = 1'b1;
        hold(2);
        reset = 1'b0; cfgEnable = 4'b0001; cfgFlash = 4'b0001; cfgBg = 12'h00F;
        layerHit = 4'b0001; dispareaIn = 1'b1;
        for (int f = 0; f < 6; f++) begin
            tickCountB = 0;
            pulseVs();
            hold(3);
            checkOutput($sformatf("t5Frame%0d", f), {rB, gB, bB}, flashExp[f]);
            checkOutput($sformatf("t5Ticks%0d", f), tickCountB, 1);
        end

        // T6: reset mid-line flushes to black until the next frame start
        checkOutput("t6Drawing", {rA, gA, bA}, 12'h888);
        reset = 1'b1;
        applyStimulus();
        checkOutput("t6ResetBlack", {rA, gA, bA}, 12'h000);
        reset = 1'b0;
        hold(3);
        checkOutput("t6StillBlack", {rA, gA, bA}, 12'h000);
        pulseVs();
        hold(2);
        checkOutput("t6ResumeA", {rA, gA, bA}, 12'h888);
        checkOutput("t6ResumeB", {rB, gB, bB}, 12'h888);

        // Randomized traffic against the model
        for (int c = 0; c < 700; c++) begin
            layerHit = 4'($urandom);
            dispareaIn = ($urandom_range(0, 3) != 0);
            hsIn = ($urandom_range(0, 5) != 0);
            vsIn = ($urandom_range(0, 7) != 0);
            layerColor = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) begin
                cfgEnable = 4'($urandom);
                cfgFlash = 4'($urandom);
                cfgBg = 12'($urandom);
            end
            reset = ($urandom_range(0, 299) == 0);
            applyStimulus();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
